// File: rtl/boot_ctrl_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// boot_ctrl_pkg : shared state encoding and UART status bytes
// Rev 1.0
// ------------------------------------------------------------------
package boot_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOADING = 3'd1,
    ACK_TX  = 3'd2,
    CNT_TX  = 3'd3,
    HOLD    = 3'd4,
    RUN     = 3'd5,
    ERR_TX  = 3'd6,
    ERROR   = 3'd7
  } boot_state_t;

  localparam logic [7:0] ACK_BYTE = 8'hA5;
  localparam logic [7:0] ERR_BYTE = 8'hEE;

endpackage
`default_nettype wire

// File: rtl/gap_timer.sv
`default_nettype none
// ------------------------------------------------------------------
// gap_timer : counts cycles since the last clear, flags the last slot
// Rev 1.0
// ------------------------------------------------------------------
module gap_timer #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic arst_n,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int c_CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(TIMEOUT_CYC - 1);

  logic [c_CW-1:0] r_count;

  // Parks on the last value so a stalled caller never sees a wrap.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (tick && (r_count != c_LAST)) begin
      r_count <= r_count + c_CW'(1);
    end
  end

  assign expired = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/boot_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------
// boot_sequencer : holds the core in reset during UART program load,
//                  arbitrates the program-memory port, reports status
// Rev 1.0
// ------------------------------------------------------------------
module boot_sequencer
  import boot_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int TIMEOUT_CYC = 100000,
  parameter int RST_HOLD    = 16
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  rx_done,
  input  logic                  ld_inst_rdy,
  input  logic [ADDR_WIDTH-1:0] ld_wr_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_prog_rdy,
  output logic                  ld_rst_n,
  input  logic                  cpu_rd_en,
  input  logic [ADDR_WIDTH-1:0] cpu_rd_addr,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_rst_n,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  input  logic                  tx_busy,
  input  logic                  reload_req,
  output logic [ADDR_WIDTH-1:0] inst_count,
  output logic [2:0]            boot_state,
  output logic                  load_err
);

  localparam int c_HOLD_W = $clog2(RST_HOLD + 1);
  localparam logic [c_HOLD_W-1:0]   c_HOLD_LAST = c_HOLD_W'(RST_HOLD - 1);
  localparam logic [ADDR_WIDTH-1:0] c_COUNT_MAX = '1;

  boot_state_t         r_state;
  logic [c_HOLD_W-1:0] r_hold_cnt;
  logic                r_busy_seen;
  logic                w_timer_clr;
  logic                w_timeout;

  assign w_timer_clr = (r_state != LOADING) || rx_done || reload_req;

  gap_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_gap_timer (
    .clk     (clk),
    .arst_n  (arst_n),
    .clear   (w_timer_clr),
    .tick    (r_state == LOADING),
    .expired (w_timeout)
  );

  assign boot_state = r_state;
  assign mem_we     = (r_state == LOADING) && ld_inst_rdy;
  assign mem_re     = (r_state == RUN) && cpu_rd_en;
  assign mem_addr   = (r_state == RUN) ? cpu_rd_addr : ld_wr_addr;
  assign mem_wdata  = ld_data;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state     <= IDLE;
      cpu_rst_n   <= 1'b0;
      ld_rst_n    <= 1'b1;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      inst_count  <= '0;
      load_err    <= 1'b0;
      r_hold_cnt  <= '0;
      r_busy_seen <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      ld_rst_n <= 1'b1;
      if (reload_req) begin
        // Overrides every state, including a byte still waiting for the UART.
        ld_rst_n <= 1'b0;
        if (r_state != IDLE) begin
          r_state    <= IDLE;
          cpu_rst_n  <= 1'b0;
          inst_count <= '0;
          load_err   <= 1'b0;
        end
      end else begin
        case (r_state)
          IDLE: begin
            cpu_rst_n <= 1'b0;
            if (rx_done) r_state <= LOADING;
          end
          LOADING: begin
            if (ld_inst_rdy && (inst_count != c_COUNT_MAX))
              inst_count <= inst_count + ADDR_WIDTH'(1);
            if (ld_prog_rdy) begin
              r_state <= ACK_TX;
            end else if (w_timeout) begin
              load_err <= 1'b1;
              r_state  <= ERR_TX;
            end
          end
          ACK_TX: begin
            if (!tx_busy) begin
              tx_start    <= 1'b1;
              tx_data     <= ACK_BYTE;
              r_busy_seen <= 1'b0;
              r_state     <= CNT_TX;
            end
          end
          CNT_TX: begin
            // Wait for the ACK byte to start and finish before queuing the count.
            if (!r_busy_seen) begin
              r_busy_seen <= tx_busy;
            end else if (!tx_busy) begin
              tx_start   <= 1'b1;
              tx_data    <= 8'(inst_count);
              r_hold_cnt <= '0;
              r_state    <= HOLD;
            end
          end
          HOLD: begin
            if (r_hold_cnt == c_HOLD_LAST) begin
              cpu_rst_n <= 1'b1;
              r_state   <= RUN;
            end else begin
              r_hold_cnt <= r_hold_cnt + c_HOLD_W'(1);
            end
          end
          RUN: begin
          end
          ERR_TX: begin
            if (!tx_busy) begin
              tx_start <= 1'b1;
              tx_data  <= ERR_BYTE;
              r_state  <= ERROR;
            end
          end
          ERROR: begin
            cpu_rst_n <= 1'b0;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_boot_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_boot_sequencer : scoreboard bench emulating loader, UART TX, core
// Rev 1.0
// ------------------------------------------------------------------
module tb_boot_sequencer;
  import boot_ctrl_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int TO = 50;
  localparam int RH = 16;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          rx_done = 1'b0, ld_inst_rdy = 1'b0, ld_prog_rdy = 1'b0;
  logic [AW-1:0] ld_wr_addr = '0, cpu_rd_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic          cpu_rd_en = 1'b0, reload_req = 1'b0, hold_busy = 1'b0;
  logic          ld_rst_n, mem_we, mem_re, cpu_rst_n, tx_start, load_err, tx_busy;
  logic [AW-1:0] mem_addr, inst_count;
  logic [DW-1:0] mem_wdata;
  logic [7:0]    tx_data;
  logic [2:0]    boot_state;

  logic m_busy = 1'b0;
  int   m_cnt = 0;
  assign tx_busy = m_busy | hold_busy;

  int n_checks = 0;
  int n_pass = 0;

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t        exp_wr[$];
  logic [7:0] exp_tx[$];

  always #5 clk = ~clk;

  boot_sequencer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYC(TO), .RST_HOLD(RH)
  ) dut (
    .clk(clk), .arst_n(arst_n), .rx_done(rx_done), .ld_inst_rdy(ld_inst_rdy),
    .ld_wr_addr(ld_wr_addr), .ld_data(ld_data), .ld_prog_rdy(ld_prog_rdy),
    .ld_rst_n(ld_rst_n), .cpu_rd_en(cpu_rd_en), .cpu_rd_addr(cpu_rd_addr),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst_n(cpu_rst_n), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .reload_req(reload_req), .inst_count(inst_count), .boot_state(boot_state),
    .load_err(load_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // UART TX model (10-cycle busy) plus scoreboards for tx bytes and memory writes.
  always @(negedge clk) begin
    if (!arst_n) begin
      m_cnt  = 0;
      m_busy = 1'b0;
    end else begin
      if (tx_start) begin
        chk("tx_start_while_busy", {63'd0, m_busy | hold_busy}, 64'd0);
        if (exp_tx.size() == 0) begin
          n_checks++;
          $display("FAIL tx_unexpected: got byte %0h, expected no transmission", tx_data);
        end else begin
          chk("tx_byte", {56'd0, tx_data}, {56'd0, exp_tx.pop_front()});
        end
        m_cnt  = 10;
        m_busy = 1'b1;
      end else if (m_cnt > 0) begin
        m_cnt--;
        m_busy = (m_cnt > 0);
      end
      if (mem_we) begin
        if (exp_wr.size() == 0) begin
          n_checks++;
          $display("FAIL mem_we_unexpected: got write to %0h, expected none", mem_addr);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("wr_addr", {54'd0, mem_addr}, {54'd0, e.a});
          chk("wr_data", {32'd0, mem_wdata}, {32'd0, e.d});
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rx_pulse();
    rx_done = 1'b1; cyc(1); rx_done = 1'b0; cyc(1);
  endtask

  task automatic write_inst(input int idx);
    ld_inst_rdy = 1'b1;
    ld_wr_addr  = AW'(idx * 4);
    ld_data     = $urandom;
    exp_wr.push_back('{ld_wr_addr, ld_data});
    cyc(1);
    ld_inst_rdy = 1'b0;
  endtask

  // Command byte, then four rx bytes per instruction, then program-ready.
  task automatic load_prog(input int n, input bit push_tx);
    rx_pulse();
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 4; b++) rx_pulse();
      write_inst(i);
    end
    if (push_tx) begin
      exp_tx.push_back(ACK_BYTE);
      exp_tx.push_back(8'(n));
    end
    ld_prog_rdy = 1'b1; cyc(1); ld_prog_rdy = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"},    {61'd0, boot_state}, {61'd0, IDLE});
    chk({tag, "_cpu_rst"},  {63'd0, cpu_rst_n}, 64'd0);
    chk({tag, "_ld_rst"},   {63'd0, ld_rst_n}, 64'd1);
    chk({tag, "_tx_start"}, {63'd0, tx_start}, 64'd0);
    chk({tag, "_tx_data"},  {56'd0, tx_data}, 64'd0);
    chk({tag, "_count"},    {54'd0, inst_count}, 64'd0);
    chk({tag, "_err"},      {63'd0, load_err}, 64'd0);
    chk({tag, "_we"},       {63'd0, mem_we}, 64'd0);
    chk({tag, "_re"},       {63'd0, mem_re}, 64'd0);
  endtask

  task automatic rst_dut();
    arst_n = 1'b0;
    exp_tx.delete(); exp_wr.delete();
    rx_done = 0; ld_inst_rdy = 0; ld_prog_rdy = 0; cpu_rd_en = 0; reload_req = 0; hold_busy = 0;
    cyc(2);
    arst_n = 1'b1;
    cyc(1);
  endtask

  task automatic areset_mid(input string tag);
    #2;
    arst_n = 1'b0;
    exp_tx.delete(); exp_wr.delete();
    #1;
    chk_reset(tag);
    cyc(2);
    arst_n = 1'b1;
    cyc(1);
  endtask

  task automatic reload_chk(input string tag);
    reload_req = 1'b1; cyc(1); reload_req = 1'b0;
    chk({tag, "_state"},   {61'd0, boot_state}, {61'd0, IDLE});
    chk({tag, "_cpu_rst"}, {63'd0, cpu_rst_n}, 64'd0);
    chk({tag, "_ld_rst0"}, {63'd0, ld_rst_n}, 64'd0);
    chk({tag, "_count"},   {54'd0, inst_count}, 64'd0);
    chk({tag, "_err"},     {63'd0, load_err}, 64'd0);
    cyc(1);
    chk({tag, "_ld_rst1"}, {63'd0, ld_rst_n}, 64'd1);
  endtask

  task automatic wait_state(input boot_state_t s, input int lim, input string name);
    int i = 0;
    while ((boot_state != s) && (i < lim)) begin
      cyc(1);
      i++;
    end
    chk(name, {61'd0, boot_state}, {61'd0, s});
  endtask

  typedef struct {
    logic en; logic [AW-1:0] ra; logic ld; logic [AW-1:0] la;
    logic we; logic re; logic [AW-1:0] ma;
  } vec_t;

  initial begin
    vec_t vecs[4];
    int   t0, t1;
    vecs[0] = '{1'b1, 10'h008, 1'b0, 10'h3FC, 1'b0, 1'b1, 10'h008};
    vecs[1] = '{1'b1, 10'h008, 1'b1, 10'h010, 1'b0, 1'b1, 10'h008};
    vecs[2] = '{1'b0, 10'h100, 1'b1, 10'h020, 1'b0, 1'b0, 10'h100};
    vecs[3] = '{1'b1, 10'h3FC, 1'b0, 10'h000, 1'b0, 1'b1, 10'h3FC};

    cyc(2);
    chk_reset("rst");
    rst_dut();

    // Normal load of three instructions through to RUN.
    load_prog(3, 1'b1);
    t0 = -1; t1 = -1;
    for (int i = 0; (i < 300) && (t1 < 0); i++) begin
      cyc(1);
      if (tx_start && (tx_data == 8'h03) && (t0 < 0)) t0 = i;
      if (cpu_rst_n && (t1 < 0)) t1 = i;
    end
    chk("release_delay", 64'(t1 - t0), 64'(RH));
    chk("run_state", {61'd0, boot_state}, {61'd0, RUN});
    chk("run_count", {54'd0, inst_count}, 64'd3);
    chk("run_err", {63'd0, load_err}, 64'd0);

    // Core owns the memory port in RUN.
    foreach (vecs[k]) begin
      cpu_rd_en = vecs[k].en; cpu_rd_addr = vecs[k].ra;
      ld_inst_rdy = vecs[k].ld; ld_wr_addr = vecs[k].la;
      #1;
      chk("vec_we",   {63'd0, mem_we}, {63'd0, vecs[k].we});
      chk("vec_re",   {63'd0, mem_re}, {63'd0, vecs[k].re});
      chk("vec_addr", {54'd0, mem_addr}, {54'd0, vecs[k].ma});
      cyc(1);
    end
    cpu_rd_en = 1'b0; ld_inst_rdy = 1'b0;
    rx_pulse();
    chk("run_ignores_rx", {61'd0, boot_state}, {61'd0, RUN});

    // Reload from RUN, IDLE, LOADING and ACK_TX.
    reload_chk("rl_run");
    reload_req = 1'b1; cyc(1); reload_req = 1'b0;
    chk("rl_idle_ld_rst", {63'd0, ld_rst_n}, 64'd0);
    chk("rl_idle_state", {61'd0, boot_state}, {61'd0, IDLE});
    cyc(1);
    rx_pulse();
    for (int b = 0; b < 4; b++) rx_pulse();
    write_inst(0);
    chk("loading_count", {54'd0, inst_count}, 64'd1);
    reload_chk("rl_load");
    hold_busy = 1'b1;
    load_prog(1, 1'b0);
    chk("ack_state", {61'd0, boot_state}, {61'd0, ACK_TX});
    reload_chk("rl_ack");
    hold_busy = 1'b0;
    cyc(30);
    chk("rl_ack_idle", {61'd0, boot_state}, {61'd0, IDLE});

    // Inter-byte timeout mid-word.
    rx_pulse();
    for (int b = 0; b < 4; b++) rx_pulse();
    write_inst(0);
    rx_pulse();
    rx_done = 1'b1; cyc(1); rx_done = 1'b0;
    cyc(TO - 1);
    chk("pre_timeout_err", {63'd0, load_err}, 64'd0);
    chk("pre_timeout_state", {61'd0, boot_state}, {61'd0, LOADING});
    exp_tx.push_back(ERR_BYTE);
    cyc(1);
    chk("timeout_err", {63'd0, load_err}, 64'd1);
    chk("timeout_state", {61'd0, boot_state}, {61'd0, ERR_TX});
    for (int i = 0; i < 6; i++) begin
      ld_inst_rdy = i[0]; cyc(1);
    end
    ld_inst_rdy = 1'b0;
    cyc(20);
    chk("error_state", {61'd0, boot_state}, {61'd0, ERROR});
    chk("error_cpu_rst", {63'd0, cpu_rst_n}, 64'd0);
    chk("error_err", {63'd0, load_err}, 64'd1);
    reload_chk("rl_err");

    // Program-ready coincident with the timeout slot and with the final write.
    rst_dut();
    rx_pulse();
    for (int b = 0; b < 4; b++) rx_pulse();
    write_inst(0);
    rx_done = 1'b1; cyc(1); rx_done = 1'b0;
    cyc(TO - 1);
    ld_inst_rdy = 1'b1; ld_wr_addr = 10'h004; ld_data = $urandom;
    exp_wr.push_back('{ld_wr_addr, ld_data});
    exp_tx.push_back(ACK_BYTE);
    exp_tx.push_back(8'h02);
    ld_prog_rdy = 1'b1; cyc(1); ld_prog_rdy = 1'b0; ld_inst_rdy = 1'b0;
    chk("coinc_state", {61'd0, boot_state}, {61'd0, ACK_TX});
    chk("coinc_err", {63'd0, load_err}, 64'd0);
    chk("coinc_count", {54'd0, inst_count}, 64'd2);
    wait_state(RUN, 200, "coinc_run");

    // Asynchronous reset while in HOLD and while a byte is being sent.
    rst_dut();
    load_prog(2, 1'b1);
    wait_state(HOLD, 100, "reach_hold");
    areset_mid("arst_hold");
    load_prog(1, 1'b1);
    for (int i = 0; (i < 20) && !tx_start; i++) cyc(1);
    chk("ack_seen", {63'd0, tx_start}, 64'd1);
    areset_mid("arst_tx");
    cyc(30);
    chk("after_arst_idle", {61'd0, boot_state}, {61'd0, IDLE});

    chk("tx_queue_drained", 64'(exp_tx.size()), 64'd0);
    chk("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
